param_sync_ram: RTL and testbench
=================================

# param_sync_ram

Parametrised single-clock, simple-dual-port RAM replacing the fixed 256x16 asynchronous-read memory in the CPU datapath. Width, depth and read-during-write mode are parameters. Reads are registered, with a valid flag. On reset, an initialisation engine sequentially clears every word to a programmable value and reports `busy` until done.

## Interface
- `DATA_W`, 16, word width in bits (1..64).
- `ADDR_W`, 8, address width in bits.
- `DEPTH`, 256, number of words; must satisfy DEPTH <= 2**ADDR_W.
- `RD_MODE`, 1, same-address read/write collision: 0 = read-first (old word), 1 = write-first (new word).
- `INIT_VALUE`, 0, DATA_W-bit value written to every word during initialisation.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset; starts/restarts initialisation.
- `wr_en`  in  1  write request.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `rd_en`  in  1  read request.
- `rd_addr`  in  ADDR_W  read address.
- `rd_data`  out  DATA_W  registered read data; holds last value when no read completes.
- `rd_valid`  out  1  one-cycle pulse, `rd_data` updated this cycle.
- `busy`  out  1  initialisation in progress; requests ignored.

## Operation
- FSM states: INIT, READY.
- `rst` high at an edge: state=INIT, clear counter=0, `busy`=1, `rd_valid`=0, `rd_data`=0. Any in-flight read is discarded.
- INIT, per edge with `rst` low: write INIT_VALUE to address counter, counter+1. After writing DEPTH-1, go to READY with `busy`=0.
- Reset during INIT restarts the clear from address 0.
- `wr_en`/`rd_en` in INIT are dropped entirely: no write, no `rd_valid`.
- READY write: `wr_en`=1 and `wr_addr` < DEPTH → word updated at edge. `wr_addr` >= DEPTH → write dropped silently.
- READY read: `rd_en`=1 → at next edge `rd_data`=word, `rd_valid`=1. `rd_addr` >= DEPTH → `rd_data`=0, `rd_valid`=1.
- Simultaneous read and write, same in-range address:
  - RD_MODE=0: returns pre-write word.
  - RD_MODE=1: returns `wr_data`.
- Different addresses: independent, both complete in the same cycle.
- No read: `rd_valid`=0, `rd_data` holds.

## Timing
- Read latency is 1 cycle: request sampled at edge N, data and valid visible after edge N.
- Write is visible to a read issued at the next edge (N+1) in both modes.
- Initialisation timing:
  - Reset sampled at edge R. Edges R+1..R+DEPTH perform the clear.
  - `busy` falls after edge R+DEPTH.
  - The first accepted request is sampled at edge R+DEPTH+1.
- Throughput is one read plus one write per cycle in READY. There is no back-pressure other than `busy`.
- Reset values: `rd_data`=0, `rd_valid`=0, `busy`=1.

## Structure
- Shared package `ram_pkg`:
  - RD_MODE constants `RD_FIRST`=0, `WR_FIRST`=1.
  - FSM state encoding: INIT, READY.
- Sub-module `sync_ram_core` holds the storage array only: one write port, one registered read port, no reset.
- Top level owns:
  - INIT FSM and clear counter.
  - Write-port mux selecting the clear path or the user path.
  - Range checks.
  - Collision bypass.
  - `rd_valid` register.
- Sized for inference as block RAM; bypass logic sits outside the core.

## Test plan
- Reset release with DEPTH=256 → `busy` high exactly 256 cycles. Reading 0x00, 0x7F and 0xFF each returns INIT_VALUE (0) with one `rd_valid` pulse.
- Write 0xBEEF to 0x12, then read 0x12 next cycle → `rd_data`=0xBEEF one cycle after the read, `rd_valid`=1 for one cycle.
- Same-cycle write 0x1234 and read at 0x05 (old 0xAAAA):
  - RD_MODE=0 → 0xAAAA.
  - RD_MODE=1 → 0x1234.
- DEPTH=200, ADDR_W=8: write 0x5555 to 0xF0 and read 0xF0 → write dropped, `rd_data`=0, `rd_valid`=1. Word 0x70 is unaffected.
- Assert `rst` at clear address 100, release → `busy` lasts a full DEPTH cycles from release. Reads issued during `busy` produce no `rd_valid`. A pre-reset write to 0x01 now reads INIT_VALUE.
- Back-to-back reads of 0x00..0x0F with concurrent writes to 0x10..0x1F → 16 consecutive `rd_valid` pulses in order. Writes verified by a second read sweep.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised synchronous RAM.
// Read-during-write modes, FSM states and read-data source select.
package ram_pkg;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_CORE,
        SRC_BYP
    } rd_src_t;

endpackage

// File: rtl/sync_ram_core.sv
// Storage array only: one write port, one registered read port, no reset.
// Kept free of bypass logic so it maps onto block RAM.
module sync_ram_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/param_sync_ram.sv
// Simple-dual-port RAM with registered read, collision bypass and a
// reset-driven clear engine that owns the write port while busy.
module param_sync_ram
    import ram_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 8,
    parameter int                DEPTH      = 256,
    parameter int                RD_MODE    = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              rd_valid_q;
    rd_src_t           rd_src_q;
    logic [DATA_W-1:0] byp_q;

    logic              ready;
    logic              wr_ok;
    logic              rd_ok;
    logic              rd_in;
    logic              byp_hit;
    logic              core_we;
    logic              core_re;
    logic [ADDR_W-1:0] core_waddr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;

    assign ready   = (state_q == READY);
    assign wr_ok   = ready & wr_en & ({1'b0, wr_addr} < DEPTH_X);
    assign rd_ok   = ready & rd_en;
    assign rd_in   = ({1'b0, rd_addr} < DEPTH_X);
    // Write-first collisions are served from a register beside the core
    assign byp_hit = (RD_MODE == WR_FIRST) & wr_ok & rd_in
                   & (wr_addr == rd_addr);

    assign core_we    = ~rst & (~ready | wr_ok);
    assign core_waddr = ready ? wr_addr : cnt_q;
    assign core_wdata = ready ? wr_data : INIT_VALUE;
    assign core_re    = ~rst & rd_ok & rd_in & ~byp_hit;

    sync_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk     (clk),
        .we_i    (core_we),
        .waddr_i (core_waddr),
        .wdata_i (core_wdata),
        .re_i    (core_re),
        .raddr_i (rd_addr),
        .rdata_o (core_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_src_q   <= SRC_ZERO;
            byp_q      <= '0;
        end else begin
            rd_valid_q <= rd_ok;
            if (rd_ok) begin
                if (!rd_in) begin
                    rd_src_q <= SRC_ZERO;
                end else if (byp_hit) begin
                    rd_src_q <= SRC_BYP;
                    byp_q    <= wr_data;
                end else begin
                    rd_src_q <= SRC_CORE;
                end
            end
            unique case (state_q)
                INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    state_q <= READY;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    // Source select is registered, so rd_data holds when no read completes
    always_comb begin
        rd_data = '0;
        unique case (rd_src_q)
            SRC_CORE: rd_data = core_rdata;
            SRC_BYP:  rd_data = byp_q;
            default:  rd_data = '0;
        endcase
    end

    assign rd_valid = rd_valid_q;
    assign busy     = (state_q == INIT);

endmodule

// File: tb/tb_param_sync_ram.sv
// Scoreboard bench: three RAM configurations driven with shared stimulus.
// Covers clear timing, read/write, collisions, range drops and restart.
module tb_param_sync_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  wr_addr;
    logic [7:0]  rd_addr;
    logic [15:0] wr_data;

    logic [15:0] rdat [3];
    logic        rv   [3];
    logic        bz   [3];

    int          dep   [3] = '{256, 256, 200};
    int          mode  [3] = '{0, 1, 1};
    logic [15:0] initv [3] = '{16'h0000, 16'h0000, 16'hA5A5};

    logic [15:0] mdl  [3][256];
    logic [15:0] sb   [3][$];
    logic [15:0] last [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    param_sync_ram #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_MODE(0),
                     .INIT_VALUE(16'h0000)) u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdat[0]), .rd_valid(rv[0]), .busy(bz[0]));

    param_sync_ram #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_MODE(1),
                     .INIT_VALUE(16'h0000)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdat[1]), .rd_valid(rv[1]), .busy(bz[1]));

    param_sync_ram #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .RD_MODE(1),
                     .INIT_VALUE(16'hA5A5)) u2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdat[2]), .rd_valid(rv[2]), .busy(bz[2]));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic init_model();
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 256; a++) mdl[i][a] = initv[i];
            sb[i].delete();
            last[i] = 16'h0000;
        end
    endtask

    task automatic apply(input logic we, input logic [7:0] wa,
                         input logic [15:0] wd, input logic re,
                         input logic [7:0] ra);
        logic [15:0] e;
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra;
        for (int i = 0; i < 3; i++) begin
            if (re) begin
                if (int'(ra) >= dep[i]) e = 16'h0000;
                else if (we && wa == ra && mode[i] == 1) e = wd;
                else e = mdl[i][ra];
                sb[i].push_back(e);
            end
        end
        for (int i = 0; i < 3; i++)
            if (we && int'(wa) < dep[i]) mdl[i][wa] = wd;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid/u%0d a%0h", i, ra), 32'(rv[i]), 32'(re));
            if (rv[i]) begin
                chk($sformatf("sbdepth/u%0d", i), sb[i].size(), 1);
                if (sb[i].size() > 0) begin
                    e = sb[i].pop_front();
                    chk($sformatf("rdata/u%0d a%0h", i, ra), 32'(rdat[i]),
                        32'(e));
                    last[i] = e;
                end
            end else begin
                chk($sformatf("hold/u%0d", i), 32'(rdat[i]), 32'(last[i]));
            end
        end
    endtask

    // Reset, then hammer requests while busy and measure the busy window
    task automatic reset_seq();
        int nb [3];
        int nv [3];
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy/u%0d", i), 32'(bz[i]), 1);
            chk($sformatf("rst_valid/u%0d", i), 32'(rv[i]), 0);
            chk($sformatf("rst_data/u%0d", i), 32'(rdat[i]), 0);
            nb[i] = 1;
            nv[i] = 0;
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            rst = 1'b0;
            wr_en = (k < 150); wr_addr = 8'h01; wr_data = 16'hDEAD;
            rd_en = (k < 150); rd_addr = 8'(k);
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (bz[i]) nb[i]++;
                if (rv[i]) nv[i]++;
            end
        end
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy_len/u%0d", i), nb[i], dep[i]);
            chk($sformatf("busy_valid/u%0d", i), nv[i], 0);
            chk($sformatf("busy_data/u%0d", i), 32'(rdat[i]), 0);
        end
        init_model();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        init_model();

        reset_seq();

        apply(0, 8'h00, 16'h0, 1, 8'h00);
        apply(0, 8'h00, 16'h0, 1, 8'h7F);
        apply(0, 8'h00, 16'h0, 1, 8'hFF);

        apply(1, 8'h12, 16'hBEEF, 0, 8'h00);
        apply(0, 8'h00, 16'h0, 1, 8'h12);
        apply(0, 8'h00, 16'h0, 0, 8'h00);

        apply(1, 8'h05, 16'hAAAA, 0, 8'h00);
        apply(1, 8'h05, 16'h1234, 1, 8'h05);
        apply(0, 8'h00, 16'h0, 1, 8'h05);

        apply(1, 8'hF0, 16'h5555, 1, 8'hF0);
        apply(0, 8'h00, 16'h0, 1, 8'h70);
        apply(0, 8'h00, 16'h0, 1, 8'hF0);

        for (int k = 0; k < 16; k++)
            apply(1, 8'(8'h10 + k), 16'(16'h0101 * (k + 1)), 1, 8'(k));
        for (int k = 0; k < 16; k++)
            apply(0, 8'h00, 16'h0, 1, 8'(8'h10 + k));

        for (int k = 0; k < 300; k++)
            apply(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  16'($urandom), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)));

        apply(1, 8'h01, 16'h7777, 0, 8'h00);
        apply(0, 8'h00, 16'h0, 1, 8'h01);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(posedge clk);
        reset_seq();

        apply(0, 8'h00, 16'h0, 1, 8'h01);
        apply(0, 8'h00, 16'h0, 1, 8'h05);
        apply(0, 8'h00, 16'h0, 1, 8'hC7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
